face_result_sender: RTL and testbench
=====================================

FACE_RESULT_SENDER -- requirements
Module: face_result_sender

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, detection-buffer entries (power of 2, >=2).
REQ-002 SHALL have port clock, input, 1, sole clock; all state changes on posedge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port face_valid, input, 1, one-cycle detection strobe from VJ pipeline.
REQ-005 SHALL have ports face_row, face_col, face_size, input, 8 each, top-left corner and window side in laptop-image pixels.
REQ-006 SHALL have port frame_done, input, 1, one-cycle pulse: pipeline finished current image.
REQ-007 SHALL have port tx_cts, input, 1, host clear-to-send.
REQ-008 SHALL have port tx_busy, input, 1, UART transmitter busy.
REQ-009 SHALL have ports tx_start (output, 1, one-cycle byte launch) and tx_data (output, 8, byte held valid while tx_start high).
REQ-010 SHALL have ports all_sent (output, 1, one-cycle pulse after terminator packet), overflow (output, 1, sticky), drop_count (output, 8, saturating dropped-detection count).

Function
REQ-011 SHALL buffer detections in a FIFO_DEPTH-entry FIFO; push on face_valid, accepted when not full or when a pop occurs in the same cycle.
REQ-012 SHALL, on face_valid with FIFO full and no same-cycle pop, drop the entry, set overflow, increment drop_count saturating at 255.
REQ-013 SHALL encode each packet as 5 bytes in order: 1, face_col, face_row, c2, r2, where c2 = face_col+face_size-1 and r2 = face_row+face_size-1, computed 9-bit and saturated to 255; face_size 0 SHALL yield c2=face_col, r2=face_row.
REQ-014 SHALL use FSM states IDLE, LOAD, SEND, GUARD, WAIT, TERM, DONE.
REQ-015 IDLE -> LOAD when FIFO non-empty; IDLE -> TERM when FIFO empty and done_pending; else stay.
REQ-016 LOAD SHALL pop one entry into a 5-byte packet register, clear byte index, go to SEND (1 cycle).
REQ-017 SEND SHALL assert tx_start with tx_data = packet[index] only in a cycle where tx_cts=1 and tx_busy=0, then go to GUARD; otherwise hold with tx_start=0.
REQ-018 GUARD SHALL last exactly 1 cycle (transmitter raises tx_busy), then WAIT.
REQ-019 WAIT SHALL exit when tx_busy=0: index<4 -> index+1, SEND; index=4 -> IDLE.
REQ-020 TERM SHALL load packet 0,0,0,0,0 and go to SEND; after its fifth byte completes, go to DONE instead of IDLE.
REQ-021 DONE SHALL pulse all_sent for 1 cycle, clear done_pending, go to IDLE.
REQ-022 frame_done SHALL set done_pending in any state; a frame_done while done_pending already set SHALL be absorbed (one terminator).
REQ-023 detections arriving after frame_done but before TERM SHALL be sent before the terminator.
REQ-024 tx_start SHALL never be high in two consecutive cycles; tx_data SHALL be 0 when tx_start=0.
REQ-025 minimum packet time SHALL be 1 (LOAD) + 5 x 3 cycles with ideal transmitter.

Reset
REQ-026 reset SHALL asynchronously force IDLE, empty FIFO, clear done_pending, index, packet register; tx_start=0, tx_data=0, all_sent=0, overflow=0, drop_count=0.
REQ-027 reset asserted mid-packet SHALL abandon the packet; no further tx_start until a new detection or frame_done after release.

Structure
REQ-028 packet length (5), terminator byte values, face_found code and FSM state enum SHALL live in the shared vj package beside LAPTOP_WIDTH/LAPTOP_HEIGHT.
REQ-029 the FIFO SHALL be a sub-module result_fifo (parameterized depth/width, full/empty, simultaneous push/pop).

Verification
REQ-030 one detection (r10,c20,size24), tx_cts=1, model transmitter busy 54 cycles -> bytes 1,20,10,43,33 in order.
REQ-031 detection r240,c250,size24 -> c2=255, r2=255 saturated.
REQ-032 10 detections back-to-back with tx_cts=0 -> 8 buffered, overflow=1, drop_count=2; release tx_cts -> 8 packets, FIFO order.
REQ-033 frame_done with 2 queued detections -> 2 packets, then 0,0,0,0,0, then one all_sent pulse.
REQ-034 tx_cts deasserted mid-packet after byte 2 -> no tx_start until tx_cts=1, then byte 3 resumes.
REQ-035 reset during WAIT of byte 3 -> outputs zero immediately, FIFO empty, no tx_start for 20 idle cycles after release.

Source files
------------

// File: rtl/vj_pkg.sv
// Shared Viola-Jones definitions: image geometry, result packet format,
// sender FSM states and the detection-to-packet encoder.
package vj_pkg;

  localparam int LAPTOP_WIDTH  = 320;
  localparam int LAPTOP_HEIGHT = 240;

  localparam int PKT_LEN = 5;
  localparam logic [7:0] FACE_FOUND = 8'd1;
  localparam logic [7:0] TERM_BYTE  = 8'd0;

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND, GUARD, WAIT, TERM, DONE
  } tx_state_e;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] size;
  } det_t;

  typedef logic [PKT_LEN-1:0][7:0] pkt_t;

  // Far corner of the window; clamps to the last pixel on 8-bit overflow.
  function automatic logic [7:0] corner(input logic [7:0] base,
                                        input logic [7:0] size);
    logic [8:0] sum;
    sum = {1'b0, base} + {1'b0, size} - 9'd1;
    if (size == 8'd0) return base;
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  function automatic pkt_t encode(input det_t d);
    pkt_t p;
    p[0] = FACE_FOUND;
    p[1] = d.col;
    p[2] = d.row;
    p[3] = corner(d.col, d.size);
    p[4] = corner(d.row, d.size);
    return p;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Show-ahead FIFO with full/empty flags; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_en, rd_en;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    rd_en    = pop && !empty;
    wr_en    = push && (!full || rd_en);
    drop     = push && !wr_en;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/face_result_sender.sv
// Queues face detections and streams them to a UART as 5-byte packets,
// closing each frame with an all-zero terminator packet.
module face_result_sender
  import vj_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       face_valid,
  input  logic [7:0] face_row,
  input  logic [7:0] face_col,
  input  logic [7:0] face_size,
  input  logic       frame_done,
  input  logic       tx_cts,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       all_sent,
  output logic       overflow,
  output logic [7:0] drop_count
);

  localparam logic [2:0] LAST = 3'(PKT_LEN - 1);

  tx_state_e  state_q;
  pkt_t       pkt_q;
  logic [2:0] idx_q;
  logic       term_q;
  logic       done_pend_q;
  logic       tx_start_q;
  logic [7:0] tx_data_q;
  logic       all_sent_q;
  logic       overflow_q, overflow_d;
  logic [7:0] drop_q, drop_d;

  det_t det_in, det_out;
  logic fifo_empty, fifo_full, fifo_drop, fifo_pop;

  assign det_in   = '{row: face_row, col: face_col, size: face_size};
  assign fifo_pop = (state_q == LOAD);

  result_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(det_t))
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push   (face_valid),
    .pop    (fifo_pop),
    .wr_data(det_in),
    .rd_data(det_out),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .drop   (fifo_drop)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pkt_q       <= '0;
      idx_q       <= '0;
      term_q      <= 1'b0;
      done_pend_q <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      all_sent_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      all_sent_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty)      state_q <= LOAD;
          else if (done_pend_q) state_q <= TERM;
        end
        LOAD: begin
          pkt_q   <= encode(det_out);
          idx_q   <= '0;
          term_q  <= 1'b0;
          state_q <= SEND;
        end
        TERM: begin
          pkt_q   <= {PKT_LEN{TERM_BYTE}};
          idx_q   <= '0;
          term_q  <= 1'b1;
          state_q <= SEND;
        end
        SEND: begin
          if (tx_cts && !tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= pkt_q[idx_q];
            state_q    <= GUARD;
          end
        end
        GUARD: state_q <= WAIT;
        WAIT: begin
          if (!tx_busy) begin
            if (idx_q == LAST) begin
              state_q <= term_q ? DONE : IDLE;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= SEND;
            end
          end
        end
        DONE: begin
          all_sent_q  <= 1'b1;
          done_pend_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // A fresh frame_done outranks the clear in DONE so it is never lost.
      if (frame_done) done_pend_q <= 1'b1;
    end
  end

  always_comb begin
    overflow_d = overflow_q | fifo_drop;
    drop_d     = drop_q;
    if (fifo_drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign all_sent   = all_sent_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_face_result_sender.sv
// Self-checking bench: byte-stream reference model, UART transmitter model,
// directed scenarios plus a randomized phase.
module tb_face_result_sender;

  logic       clock = 1'b0;
  logic       reset;
  logic       face_valid;
  logic [7:0] face_row, face_col, face_size;
  logic       frame_done;
  logic       tx_cts;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       all_sent;
  logic       overflow;
  logic [7:0] drop_count;

  face_result_sender #(.FIFO_DEPTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .face_valid(face_valid),
    .face_row  (face_row),
    .face_col  (face_col),
    .face_size (face_size),
    .frame_done(frame_done),
    .tx_cts    (tx_cts),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .all_sent  (all_sent),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] log_q[$];
  int term_pending = 0;
  int as_cnt = 0;

  int busy_len = 3;
  bit busy_rand = 1'b0;
  int busy_cnt;

  assign tx_busy = (busy_cnt != 0);

  always @(posedge clock or posedge reset) begin
    if (reset) busy_cnt <= 0;
    else if (tx_start)
      busy_cnt <= busy_rand ? int'($urandom_range(0, 4)) : busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int far_px(input int base, input int size);
    if (size == 0) return base;
    return (base + size - 1 > 255) ? 255 : base + size - 1;
  endfunction

  task automatic push_exp(input int r, input int c, input int s);
    exp_q.push_back(8'd1);
    exp_q.push_back(8'(c));
    exp_q.push_back(8'(r));
    exp_q.push_back(8'(far_px(c, s)));
    exp_q.push_back(8'(far_px(r, s)));
  endtask

  task automatic push_term();
    repeat (5) exp_q.push_back(8'd0);
    term_pending++;
  endtask

  bit prev_start = 1'b0;
  bit prev_cts = 1'b0;
  bit prev_busy = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      if (!tx_start) chk("tx_data_idle", tx_data, 0);
      if (tx_start) begin
        chk("tx_start_back_to_back", int'(prev_start), 0);
        chk("tx_start_gate", int'(prev_cts && !prev_busy), 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_tx", tx_data, 256);
        end else begin
          chk("tx_byte", tx_data, exp_q.pop_front());
        end
        log_q.push_back(tx_data);
      end
      if (all_sent) begin
        as_cnt++;
        chk("all_sent_timing", int'(term_pending > 0 && exp_q.size() == 0), 1);
        if (term_pending > 0) term_pending--;
      end
      prev_start = tx_start;
      prev_cts   = tx_cts;
      prev_busy  = tx_busy;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic det(input int r, input int c, input int s);
    face_valid = 1'b1;
    face_row   = 8'(r);
    face_col   = 8'(c);
    face_size  = 8'(s);
    tick();
    face_valid = 1'b0;
  endtask

  task automatic fdone();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while ((exp_q.size() != 0 || term_pending != 0) && k < limit) begin
      tick();
      k++;
    end
    chk("drain_timeout", exp_q.size() + term_pending, 0);
    repeat (60) tick();
  endtask

  task automatic wait_log(input int n, input int limit);
    int k = 0;
    while (log_q.size() < n && k < limit) begin
      tick();
      k++;
    end
    chk("wait_log_timeout", int'(log_q.size() >= n), 1);
  endtask

  initial begin
    reset = 1'b1;
    face_valid = 1'b0;
    face_row = '0;
    face_col = '0;
    face_size = '0;
    frame_done = 1'b0;
    tx_cts = 1'b0;
    repeat (3) tick();
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_all_sent", all_sent, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_count", drop_count, 0);
    reset = 1'b0;
    tick();

    // one detection, slow transmitter
    tx_cts = 1'b1;
    busy_len = 54;
    log_q.delete();
    push_exp(10, 20, 24);
    det(10, 20, 24);
    drain(2000);
    begin
      logic [7:0] lit[5] = '{8'd1, 8'd20, 8'd10, 8'd43, 8'd33};
      chk("basic_len", log_q.size(), 5);
      for (int i = 0; i < 5 && i < log_q.size(); i++)
        chk($sformatf("basic_b%0d", i), log_q[i], lit[i]);
    end

    // corner saturation and zero size
    busy_len = 2;
    log_q.delete();
    push_exp(240, 250, 24);
    det(240, 250, 24);
    push_exp(7, 9, 0);
    det(7, 9, 0);
    drain(2000);
    chk("sat_len", log_q.size(), 10);
    if (log_q.size() == 10) begin
      chk("sat_c2", log_q[3], 255);
      chk("sat_r2", log_q[4], 255);
      chk("zero_c2", log_q[8], 9);
      chk("zero_r2", log_q[9], 7);
    end

    // overflow: one packet parked in SEND, ten more arrive
    tx_cts = 1'b0;
    log_q.delete();
    push_exp(1, 1, 1);
    det(1, 1, 1);
    repeat (5) tick();
    for (int i = 0; i < 10; i++) begin
      face_valid = 1'b1;
      face_row   = 8'(i * 10);
      face_col   = 8'(i * 10 + 5);
      face_size  = 8'(i + 1);
      if (i < 8) push_exp(i * 10, i * 10 + 5, i + 1);
      tick();
    end
    face_valid = 1'b0;
    tick();
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop_count", drop_count, 2);
    tx_cts = 1'b1;
    drain(3000);
    chk("ovf_pkt_bytes", log_q.size(), 45);
    chk("ovf_sticky", overflow, 1);

    // frame end with queued detections, late detection, double frame_done
    tx_cts = 1'b0;
    as_cnt = 0;
    log_q.delete();
    push_exp(3, 4, 5);
    det(3, 4, 5);
    repeat (5) tick();
    push_exp(30, 40, 50);
    det(30, 40, 50);
    push_exp(60, 70, 80);
    det(60, 70, 80);
    fdone();
    push_exp(90, 100, 110);
    det(90, 100, 110);
    push_term();
    tick();
    fdone();
    tx_cts = 1'b1;
    drain(3000);
    chk("frame_all_sent_pulses", as_cnt, 1);
    chk("frame_bytes", log_q.size(), 25);

    // transmitter not clear-to-send mid-packet
    busy_len = 3;
    log_q.delete();
    push_exp(11, 22, 33);
    det(11, 22, 33);
    wait_log(2, 500);
    tx_cts = 1'b0;
    repeat (30) tick();
    chk("cts_hold_bytes", log_q.size(), 2);
    tx_cts = 1'b1;
    drain(2000);
    chk("cts_resume_len", log_q.size(), 5);
    if (log_q.size() == 5) chk("cts_resume_b3", log_q[2], 11);

    // reset while waiting on the third byte
    busy_len = 54;
    log_q.delete();
    push_exp(5, 6, 7);
    det(5, 6, 7);
    push_exp(8, 9, 10);
    det(8, 9, 10);
    wait_log(3, 1000);
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_tx_start", tx_start, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_all_sent", all_sent, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_drop_count", drop_count, 0);
    exp_q.delete();
    term_pending = 0;
    log_q.delete();
    tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("post_rst_silent", log_q.size(), 0);

    // randomized traffic, then one frame terminator
    busy_rand = 1'b1;
    as_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      tx_cts = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 4) == 0 && (exp_q.size() + 4) / 5 < 8) begin
        int r, c, s;
        r = $urandom_range(0, 255);
        c = $urandom_range(0, 255);
        case ($urandom_range(0, 3))
          0:       s = 0;
          1:       s = 255;
          default: s = $urandom_range(1, 64);
        endcase
        push_exp(r, c, s);
        det(r, c, s);
      end else begin
        tick();
      end
    end
    tx_cts = 1'b1;
    fdone();
    push_term();
    repeat (3) tick();
    fdone();
    drain(5000);
    chk("rand_all_sent_pulses", as_cnt, 1);
    chk("rand_no_drops", drop_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
